// File: rtl/grng_feed_scheduler.sv
// Purpose : gathers seven entropy words into a 56-bit probability pool, runs one
//           decision-tree sample per pool and delivers it to one of NREQ requesters
//           chosen round-robin.
// Latency : a request seen while the pool is full gives out_valid two edges later.
//           With continuous entropy and requests, one sample every 10 cycles.
// Backpressure: ent_ready is high only while filling. A held sample waits
//           indefinitely for its grantee's req, and nobody else is served meanwhile.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ent_data/valid/rdy  entropy word input (valid/ready handshake)
//   tree_pbits          probability-bit pool to the sampler
//   tree_result         combinational sampler output for tree_pbits
//   req[NREQ]           per-requester level request, also the requester's ready
//   out_valid[NREQ]     one-hot offer of out_data
//   out_data            registered sample
//   samples_issued      wrapping count of completed deliveries
module grng_feed_scheduler #(
    parameter int NREQ  = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       ent_data,
    input  logic             ent_valid,
    output logic             ent_ready,
    output logic [55:0]      tree_pbits,
    input  logic [7:0]       tree_result,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  out_valid,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] samples_issued
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8) begin : g_nreq_range
        $error("grng_feed_scheduler: NREQ must be in 2..8");
    end

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_READY = 2'd1,
        S_EVAL  = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       k_q, k_d;
    logic [55:0]      pool_q, pool_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    gnt_q, gnt_d;
    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    rr_pick;

    // (base + off) mod NREQ for off in 0..NREQ-1; NREQ need not be a power of two.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return PW'(s);
    endfunction

    // Round-robin pick: scanning offsets from high to low and overwriting means
    // the smallest offset from ptr with an active req wins.
    always_comb begin
        rr_pick = ptr_q;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[wrap_idx(ptr_q, i)]) begin
                rr_pick = wrap_idx(ptr_q, i);
            end
        end
    end

    // Pool byte fields seen by the sampler: pbits7=pool[0], pbits6=pool[1],
    // pbits5=pool[3:2], pbits4=pool[7:4], pbits3=pool[15:8], pbits2=pool[31:16],
    // pbits1=pool[47:32], pbits0=pool[55:48]. The whole pool is driven as-is.
    assign tree_pbits     = pool_q;
    assign out_data       = data_q;
    assign samples_issued = cnt_q;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        pool_d    = pool_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        ent_ready = 1'b0;
        out_valid = '0;

        case (state_q)
            S_FILL: begin
                ent_ready = 1'b1;
                if (ent_valid) begin
                    pool_d[{k_q, 3'b000} +: 8] = ent_data;
                    k_d = k_q + 3'd1;
                    if (k_q == 3'd6) begin
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                // Arbitration happens only here; req is ignored for it elsewhere.
                if (|req) begin
                    gnt_d   = rr_pick;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                data_d  = tree_result;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                out_valid[gnt_q] = 1'b1;
                if (req[gnt_q]) begin
                    ptr_d   = wrap_idx(gnt_q, 1);
                    cnt_d   = cnt_q + CNT_W'(1);
                    k_d     = 3'd0;
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FILL;
            k_q     <= 3'd0;
            pool_q  <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            pool_q  <= pool_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_grng_feed_scheduler.sv
// Purpose : self-checking bench for grng_feed_scheduler with directed scenarios
//           followed by randomized entropy/request traffic against a reference model.
// Latency : n/a.  Backpressure: bench drives ent_valid/req freely.
module tb_grng_feed_scheduler;

    localparam int NREQ  = 3;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       ent_data;
    logic             ent_valid;
    logic             ent_ready;
    logic [55:0]      tree_pbits;
    logic [7:0]       tree_result;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  out_valid;
    logic [7:0]       out_data;
    logic [CNT_W-1:0] samples_issued;
    logic             tie_a5;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference model: words collected for the current pool, grant, sample.
    logic [55:0] m_pool;
    int          m_nwords;
    int          m_gnt;
    bit          m_loaded;
    logic [7:0]  m_data;
    int          m_ptr;
    int          m_cnt;

    always #5 clk = ~clk;

    // Order-sensitive stand-in for the decision-tree sampler.
    function automatic logic [7:0] smp(input logic [55:0] p);
        logic [7:0] s;
        s = 8'h5A;
        for (int i = 0; i < 7; i++) begin
            s = {s[6:0], s[7]} ^ p[8*i +: 8];
        end
        return s;
    endfunction

    assign tree_result = tie_a5 ? 8'hA5 : smp(tree_pbits);

    grng_feed_scheduler #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ent_data       (ent_data),
        .ent_valid      (ent_valid),
        .ent_ready      (ent_ready),
        .tree_pbits     (tree_pbits),
        .tree_result    (tree_result),
        .req            (req),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .samples_issued (samples_issued)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic int m_pick(input int ptr, input logic [NREQ-1:0] r);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pool   = '0;
        m_nwords = 0;
        m_gnt    = -1;
        m_loaded = 1'b0;
        m_data   = 8'h00;
        m_ptr    = 0;
        m_cnt    = 0;
    endtask

    // One clock edge of behaviour: fill until 7 words, then grant, then sample,
    // then wait for the grantee to take it.
    task automatic model_step();
        if (m_nwords < 7) begin
            if (ent_valid) begin
                m_pool[8*m_nwords +: 8] = ent_data;
                m_nwords++;
            end
        end else if (m_gnt < 0) begin
            if (req != '0) m_gnt = m_pick(m_ptr, req);
        end else if (!m_loaded) begin
            m_loaded = 1'b1;
            m_data   = tie_a5 ? 8'hA5 : smp(m_pool);
        end else if (req[m_gnt]) begin
            m_ptr    = (m_gnt + 1) % NREQ;
            m_cnt    = m_cnt + 1;
            m_nwords = 0;
            m_gnt    = -1;
            m_loaded = 1'b0;
        end
    endtask

    task automatic check_all();
        logic [NREQ-1:0] ov;
        ov = '0;
        if (m_gnt >= 0 && m_loaded) ov[m_gnt] = 1'b1;
        chk("ent_ready", 64'(ent_ready), 64'(m_nwords < 7));
        chk("out_valid", 64'(out_valid), 64'(ov));
        chk("out_data", 64'(out_data), 64'(m_data));
        chk("samples_issued", 64'(samples_issued), 64'(m_cnt % (1 << CNT_W)));
        if (m_nwords == 7) chk("tree_pbits", 64'(tree_pbits), 64'(m_pool));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        ent_valid = 1'b0;
        ent_data  = 8'h00;
        req       = '0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        check_all();
    endtask

    initial begin
        int              nw;
        int              nrise;
        int              rise_cyc[4];
        logic [NREQ-1:0] rise_g[4];
        logic [NREQ-1:0] prev;
        logic [55:0]     pool_c;
        logic [7:0]      exp_s;

        rst_n = 1'b0; ent_valid = 1'b0; ent_data = 8'h00; req = '0; tie_a5 = 1'b0;
        model_reset();

        // Reset state
        do_reset();
        chk("rst_ent_ready", 64'(ent_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_count", 64'(samples_issued), 64'd0);
        chk("rst_pool", 64'(tree_pbits), 64'd0);

        // Straight fill with 0x01..0x07
        ent_valid = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            ent_data = 8'(i);
            tick();
        end
        ent_valid = 1'b0;
        chk("fill_ready_low", 64'(ent_ready), 64'd0);
        chk("fill_pool", 64'(tree_pbits), 64'h0007060504030201);
        tick();
        chk("ready_idle_ov", 64'(out_valid), 64'd0);
        chk("ready_idle_pool", 64'(tree_pbits), 64'h0007060504030201);

        // Latency with sampler tied to 0xA5
        tie_a5 = 1'b1;
        req    = 3'b001;
        tick();
        chk("lat_t1_ov", 64'(out_valid), 64'd0);
        tick();
        chk("lat_t2_ov", 64'(out_valid), 64'b001);
        chk("lat_data", 64'(out_data), 64'hA5);
        tick();
        chk("deliv_count", 64'(samples_issued), 64'd1);
        chk("deliv_ready", 64'(ent_ready), 64'd1);
        req    = '0;
        tie_a5 = 1'b0;

        // Gapped entropy: valid 1,0,0,1,0,0,...
        nw = 0;
        for (int i = 0; i < 30 && nw < 7; i++) begin
            ent_valid = (i % 3 == 0);
            ent_data  = ent_valid ? 8'(17 * (nw + 1)) : 8'hEE;
            tick();
            if (ent_valid) nw++;
        end
        ent_valid = 1'b0;
        pool_c = 56'h77665544332211;
        exp_s  = smp(pool_c);
        chk("gap_pool", 64'(tree_pbits), 64'(pool_c));
        chk("gap_ready_low", 64'(ent_ready), 64'd0);

        // Grantee (1, since ptr moved past 0) drops req while requester 0 asks
        req = 3'b011;
        tick();
        tick();
        chk("hold_ov", 64'(out_valid), 64'b010);
        chk("hold_data", 64'(out_data), 64'(exp_s));
        req = 3'b001;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ov", 64'(out_valid), 64'b010);
            chk("stall_data", 64'(out_data), 64'(exp_s));
        end
        req = 3'b011;
        tick();
        chk("stall_deliv_count", 64'(samples_issued), 64'd2);
        chk("stall_deliv_ready", 64'(ent_ready), 64'd1);
        ent_valid = 1'b1;
        for (int w = 0; w < 20 && out_valid == '0; w++) begin
            ent_data = 8'($urandom);
            tick();
        end
        chk("next_grant_other", 64'(out_valid), 64'b001);

        // Alternating grants, 10 cycles apart
        do_reset();
        req = 3'b011; ent_valid = 1'b1;
        nrise = 0; prev = '0;
        for (int i = 0; i < 60; i++) begin
            ent_data = 8'($urandom);
            tick();
            if (out_valid != '0 && prev == '0) begin
                rise_cyc[nrise] = cyc;
                rise_g[nrise]   = out_valid;
                nrise++;
            end
            prev = out_valid;
            if (nrise == 4) begin
                req = '0;
                break;
            end
        end
        chk("alt_rises", 64'(nrise), 64'd4);
        chk("alt_g0", 64'(rise_g[0]), 64'b001);
        chk("alt_g1", 64'(rise_g[1]), 64'b010);
        chk("alt_g2", 64'(rise_g[2]), 64'b001);
        chk("alt_g3", 64'(rise_g[3]), 64'b010);
        for (int i = 1; i < 4; i++) begin
            chk("alt_period", 64'(rise_cyc[i] - rise_cyc[i-1]), 64'd10);
        end

        // Asynchronous reset while holding the fourth sample
        chk("pre_rst_count", 64'(samples_issued), 64'd3);
        chk("pre_rst_ov", 64'(out_valid), 64'b010);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", 64'(out_valid), 64'd0);
        chk("arst_count", 64'(samples_issued), 64'd0);
        chk("arst_data", 64'(out_data), 64'd0);
        chk("arst_pool", 64'(tree_pbits), 64'd0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        check_all();
        ent_valid = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            ent_data = 8'(8'hA0 + i);
            tick();
        end
        chk("refill_pool", 64'(tree_pbits), 64'h00A7A6A5A4A3A2A1);

        // Counter wrap with a 4-bit counter
        req = 3'b001;
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 20 && out_valid == '0; w++) begin
                ent_data = 8'($urandom);
                tick();
            end
            if (out_valid == '0) begin
                chk("wrap_timeout", 64'd0, 64'd1);
                break;
            end
            tick();
            if (s == 14) chk("wrap_15", 64'(samples_issued), 64'd15);
            if (s == 15) chk("wrap_0", 64'(samples_issued), 64'd0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ent_valid = ($urandom_range(0, 3) != 0);
            ent_data  = 8'($urandom);
            req       = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom_range(0, 7));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
